// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble.
// Each clock does one right shift and per-digit correction, with a start/busy/done handshake.
module bcd_to_bin_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [WORK_W-1:0]   work_r, work_nxt_s, step_s;
    logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
    logic                invalid_r, invalid_nxt_s;
    logic                busy_r, busy_nxt_s;
    logic                done_r, done_nxt_s;
    logic [BIN_W-1:0]    bin_r, bin_nxt_s;
    logic                err_r, err_nxt_s;

    // One reverse double-dabble step: shift right, then pull every BCD nibble >= 8 back by 3.
    function automatic logic [WORK_W-1:0] dabble_step(input logic [WORK_W-1:0] w);
        logic [WORK_W-1:0] s;
        s = {1'b0, w[WORK_W-1:1]};
        for (int i = 0; i < DIGITS; i++) begin
            if (s[BIN_W+4*i +: 4] >= 4'd8) begin
                s[BIN_W+4*i +: 4] = s[BIN_W+4*i +: 4] - 4'd3;
            end else begin
                s[BIN_W+4*i +: 4] = s[BIN_W+4*i +: 4];
            end
        end
        return s;
    endfunction

    function automatic logic has_bad_digit(input logic [BCD_W-1:0] b);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction

    // Step datapath evaluated every cycle; only consumed in SHIFT.
    always_comb begin
        step_s = dabble_step(work_r);
    end

    // Next-state, datapath and output logic.
    always_comb begin
        state_nxt_s   = state_r;
        work_nxt_s    = work_r;
        cnt_nxt_s     = cnt_r;
        invalid_nxt_s = invalid_r;
        busy_nxt_s    = busy_r;
        done_nxt_s    = 1'b0;
        bin_nxt_s     = bin_r;
        err_nxt_s     = err_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    work_nxt_s    = {bcd_in, {BIN_W{1'b0}}};
                    cnt_nxt_s     = CNT_W'(BIN_W);
                    invalid_nxt_s = has_bad_digit(bcd_in);
                    busy_nxt_s    = 1'b1;
                    state_nxt_s   = SHIFT;
                end else begin
                    busy_nxt_s    = 1'b0;
                end
            end
            SHIFT: begin
                work_nxt_s = step_s;
                if (cnt_r > CNT_W'(1)) begin
                    cnt_nxt_s  = cnt_r - CNT_W'(1);
                    busy_nxt_s = 1'b1;
                end else begin
                    // Leftover BCD weight means the operand did not fit in BIN_W bits.
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    busy_nxt_s  = 1'b0;
                    done_nxt_s  = 1'b1;
                    err_nxt_s   = invalid_r | (step_s[WORK_W-1:BIN_W] != {BCD_W{1'b0}});
                    bin_nxt_s   = err_nxt_s ? {BIN_W{1'b0}} : step_s[BIN_W-1:0];
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            work_r    <= {WORK_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            invalid_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            bin_r     <= {BIN_W{1'b0}};
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            work_r    <= work_nxt_s;
            cnt_r     <= cnt_nxt_s;
            invalid_r <= invalid_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
            bin_r     <= bin_nxt_s;
            err_r     <= err_nxt_s;
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign bin_out = bin_r;
    assign err     = err_r;

endmodule
